uart_tx_sched: RTL and testbench

//  Drain sequencer between the TX byte FIFO (non-FWFT, rd_data valid only while rd_en high)
//  and the UART transmitter. Pops one byte per frame, launches it with a one-cycle start

---
 rtl/uart_tx_sched.sv | 119 +++++++++++
 tb/tb_uart_tx_sched.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: pops TX FIFO bytes, launches UART frames, counts completed frames.
// Define UART_TX_SCHED_GAP_EN to insert GapCycles idle cycles between frames.
module uart_tx_sched #(
  parameter int DataWidth    = 8,
  parameter int StartTimeout = 16,
  parameter int GapCycles    = 4,
  parameter int CntWidth     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic                 i_fifo_empty,
  input  logic [DataWidth-1:0] i_fifo_rd_data,
  output logic                 o_fifo_rd_en,
  output logic [DataWidth-1:0] o_tx_data,
  output logic                 o_tx_start,
  input  logic                 i_tx_busy,
  output logic                 o_busy,
  output logic                 o_tx_timeout,
  output logic [CntWidth-1:0]  o_frame_cnt
);
  localparam int TW = $clog2(StartTimeout);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FETCH     = 3'd1;
  localparam logic [2:0] LAUNCH    = 3'd2;
  localparam logic [2:0] WAIT_BUSY = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;
`ifdef UART_TX_SCHED_GAP_EN
  localparam logic [2:0] GAP       = 3'd5;
  localparam int GW = (GapCycles > 1) ? $clog2(GapCycles) : 1;
`endif

  if (StartTimeout < 2 || GapCycles < 1) begin : g_bad_cfg
    $error("uart_tx_sched: StartTimeout must be >= 2 and GapCycles >= 1");
  end

  logic [2:0]           state_q, state_d;
  logic [DataWidth-1:0] tx_data_q, tx_data_d;
  logic [CntWidth-1:0]  frame_cnt_q, frame_cnt_d;
  logic [TW-1:0]        to_cnt_q, to_cnt_d;
  logic                 fetch_ok, to_hit;
`ifdef UART_TX_SCHED_GAP_EN
  logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
`endif

  assign fetch_ok = i_enable && !i_fifo_empty;
  assign to_hit   = to_cnt_q == TW'(StartTimeout - 1);

  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    frame_cnt_d = frame_cnt_q;
    to_cnt_d    = to_cnt_q;
`ifdef UART_TX_SCHED_GAP_EN
    gap_cnt_d   = gap_cnt_q;
`endif
    case (state_q)
      IDLE:   state_d = fetch_ok ? FETCH : IDLE;
      FETCH: begin
        tx_data_d = i_fifo_rd_data;
        state_d   = LAUNCH;
      end
      LAUNCH: begin
        to_cnt_d = '0;
        state_d  = WAIT_BUSY;
      end
      // busy wins over the timeout on the last allowed cycle
      WAIT_BUSY: begin
        state_d  = i_tx_busy ? WAIT_DONE : to_hit ? IDLE : WAIT_BUSY;
        to_cnt_d = (i_tx_busy || to_hit) ? to_cnt_q : to_cnt_q + 1'b1;
      end
      WAIT_DONE: begin
        if (!i_tx_busy) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
`ifdef UART_TX_SCHED_GAP_EN
          gap_cnt_d   = GW'(GapCycles - 1);
          state_d     = GAP;
`else
          state_d     = fetch_ok ? FETCH : IDLE;
`endif
        end
      end
`ifdef UART_TX_SCHED_GAP_EN
      GAP: begin
        state_d   = (gap_cnt_q == '0) ? (fetch_ok ? FETCH : IDLE) : GAP;
        gap_cnt_d = (gap_cnt_q == '0) ? gap_cnt_q : gap_cnt_q - 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      tx_data_q   <= '0;
      frame_cnt_q <= '0;
      to_cnt_q    <= '0;
`ifdef UART_TX_SCHED_GAP_EN
      gap_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      frame_cnt_q <= frame_cnt_d;
      to_cnt_q    <= to_cnt_d;
`ifdef UART_TX_SCHED_GAP_EN
      gap_cnt_q   <= gap_cnt_d;
`endif
    end
  end

  assign o_fifo_rd_en = state_q == FETCH;
  assign o_tx_start   = state_q == LAUNCH;
  assign o_busy       = state_q != IDLE;
  assign o_tx_timeout = state_q == WAIT_BUSY && !i_tx_busy && to_hit;
  assign o_tx_data    = tx_data_q;
  assign o_frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: timestamp-based reference model with directed and random stimulus.
module tb_uart_tx_sched;
  localparam int DW = 8, ST = 16, GC = 4, CW = 4;
`ifdef UART_TX_SCHED_GAP_EN
  localparam int GX = GC;
`else
  localparam int GX = 0;
`endif

  logic clk = 0;
  always #5 clk = ~clk;

  logic i_rst_n, i_enable, i_fifo_empty, i_tx_busy;
  logic [DW-1:0] i_fifo_rd_data, o_tx_data, head;
  logic o_fifo_rd_en, o_tx_start, o_busy, o_tx_timeout;
  logic [CW-1:0] o_frame_cnt;

  // data is garbage outside the pop cycle, so a mistimed capture shows up
  assign i_fifo_rd_data = o_fifo_rd_en ? head : ~head;

  uart_tx_sched #(.DataWidth(DW), .StartTimeout(ST), .GapCycles(GC), .CntWidth(CW)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_fifo_empty(i_fifo_empty),
    .i_fifo_rd_data(i_fifo_rd_data), .o_fifo_rd_en(o_fifo_rd_en), .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start), .i_tx_busy(i_tx_busy), .o_busy(o_busy),
    .o_tx_timeout(o_tx_timeout), .o_frame_cnt(o_frame_cnt));

  int tests = 0, fails = 0, cyc = 0;
  logic [DW-1:0] fifo_q[$];
  bit pop_pending, armed, en_n, rst_n_n, rand_tx, noresp;
  int bs = -1, be = -1, lat_cfg, len_cfg;
  int rd_cyc, start_cyc, to_cyc, fall_gap, n_rd, n_start;
  logic [DW-1:0] data_at_start;
  bit m_idle, m_watch, m_intx;
  int m_fetch, m_launch, m_decide, m_wstart, m_cnt;
  logic [DW-1:0] m_data;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_idle = 1; m_watch = 0; m_intx = 0;
    m_fetch = -1; m_launch = -1; m_decide = -1; m_wstart = -1; m_cnt = 0; m_data = '0;
  endtask

  task automatic evaluate();
    bit to_e, idle_now, watch_now, intx_now;
    int r;
    if (armed) begin
      to_e = m_watch && !i_tx_busy && (cyc - m_wstart == ST - 1);
      chk("rd_en", o_fifo_rd_en, cyc == m_fetch);
      chk("tx_start", o_tx_start, cyc == m_launch);
      chk("busy", o_busy, !m_idle);
      chk("timeout", o_tx_timeout, to_e);
      chk("tx_data", o_tx_data, m_data);
      chk("frame_cnt", o_frame_cnt, m_cnt);
      chk("no_underflow", o_fifo_rd_en && i_fifo_empty, 0);
      idle_now = m_idle; watch_now = m_watch; intx_now = m_intx;
      if (cyc == m_fetch) m_data = head;
      if (cyc == m_launch) begin m_watch = 1; m_wstart = cyc + 1; end
      if (watch_now) begin
        if (i_tx_busy) begin m_watch = 0; m_intx = 1; end
        else if (to_e) begin m_watch = 0; m_idle = 1; end
      end
      if (intx_now && !i_tx_busy) begin
        m_intx = 0; m_cnt = (m_cnt + 1) % (1 << CW); m_decide = cyc + GX;
      end
      if (idle_now || cyc == m_decide) begin
        if (i_enable && !i_fifo_empty) begin
          m_idle = 0; m_fetch = cyc + 1; m_launch = cyc + 2;
        end else m_idle = 1;
      end
      if (!i_rst_n) model_reset();
    end
    if (o_fifo_rd_en === 1'b1) begin rd_cyc = cyc; n_rd++; end
    if (o_tx_timeout === 1'b1) to_cyc = cyc;
    if (o_tx_start === 1'b1) begin
      start_cyc = cyc; n_start++; data_at_start = o_tx_data; fall_gap = cyc - be;
      if (rand_tx) begin
        r = $urandom_range(0, 9);
        noresp = r == 9;
        lat_cfg = r < 7 ? r % 4 : r == 7 ? ST - 1 : ST;
        len_cfg = $urandom_range(1, 12);
      end
      bs = noresp ? -1 : cyc + 1 + lat_cfg;
      be = noresp ? -1 : bs + len_cfg;
    end
    pop_pending = o_fifo_rd_en === 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    if (!i_rst_n) armed = 1;
    #1;
    cyc++;
    if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
    i_enable = en_n;
    i_rst_n = rst_n_n;
    i_tx_busy = cyc >= bs && cyc < be;
    i_fifo_empty = fifo_q.size() == 0;
    head = fifo_q.size() > 0 ? fifo_q[0] : DW'($urandom);
    @(negedge clk);
    evaluate();
  endtask

  initial begin
    int k;
    i_rst_n = 0; i_enable = 0; i_tx_busy = 0; i_fifo_empty = 1; head = '0;
    en_n = 0; rst_n_n = 0; rand_tx = 0; noresp = 0; lat_cfg = 2; len_cfg = 10;
    model_reset();
    repeat (3) step();
    chk("rst_busy", o_busy, 0);
    chk("rst_cnt", o_frame_cnt, 0);
    chk("rst_data", o_tx_data, 0);
    chk("rst_strobes", {o_fifo_rd_en, o_tx_start, o_tx_timeout}, 0);

    rst_n_n = 1; en_n = 1; fifo_q.push_back(8'hA5);
    repeat (30) step();
    chk("t1_rd_to_start", start_cyc - rd_cyc, 1);
    chk("t1_data", data_at_start, 8'hA5);
    chk("t1_cnt", o_frame_cnt, 1);
    chk("t1_idle", o_busy, 0);

    lat_cfg = 0; len_cfg = 10; fifo_q.push_back(8'h3C); fifo_q.push_back(8'h5A);
    repeat (60) step();
    chk("t2_fall_to_start", fall_gap, GX + 2);
    chk("t2_data", data_at_start, 8'h5A);
    chk("t2_cnt", o_frame_cnt, 3);
    chk("t2_fifo_empty", fifo_q.size(), 0);
    chk("t2_starts", n_start, 3);

    noresp = 1; fifo_q.push_back(8'h77);
    repeat (40) step();
    chk("t4_timeout_delay", to_cyc - start_cyc, ST);
    chk("t4_cnt", o_frame_cnt, 3);
    chk("t4_idle", o_busy, 0);
    noresp = 0;

    lat_cfg = 1; len_cfg = 8;
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
    k = n_start;
    for (int i = 0; i < 20 && n_start == k; i++) step();
    chk("t5_started", n_start, k + 1);
    en_n = 0; k = n_rd;
    repeat (40) step();
    chk("t5_left", fifo_q.size(), 2);
    chk("t5_no_rd", n_rd - k, 0);
    chk("t5_idle", o_busy, 0);
    chk("t5_cnt", o_frame_cnt, 4);

    en_n = 1; lat_cfg = 0; len_cfg = 10;
    for (int i = 0; i < 20 && !i_tx_busy; i++) step();
    chk("t6_busy_seen", i_tx_busy, 1);
    step(); step();
    rst_n_n = 0; step();
    rst_n_n = 1; en_n = 0; step();
    chk("t6_busy", o_busy, 0);
    chk("t6_cnt", o_frame_cnt, 0);
    chk("t6_data", o_tx_data, 0);
    chk("t6_strobes", {o_fifo_rd_en, o_tx_start, o_tx_timeout}, 0);

    repeat (15) step();
    lat_cfg = 0; len_cfg = 3; k = n_start;
    for (int i = 0; i < 15; i++) fifo_q.push_back(DW'(i + 8'h40));
    en_n = 1;
    repeat (260) step();
    chk("wrap_starts", n_start - k, 16);
    chk("wrap_cnt", o_frame_cnt, 0);

    rand_tx = 1;
    for (int i = 0; i < 1500; i++) begin
      step();
      if ($urandom_range(0, 3) == 0 && fifo_q.size() < 8) fifo_q.push_back(DW'($urandom));
      if ($urandom_range(0, 19) == 0) en_n = !en_n;
      rst_n_n = $urandom_range(0, 299) != 0;
    end

    rand_tx = 0; noresp = 0; lat_cfg = 0; len_cfg = 2; en_n = 1; rst_n_n = 1;
    repeat (200) step();
    chk("drain_fifo", fifo_q.size(), 0);
    chk("drain_idle", o_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
